// File: rtl/offset_ctrl_param.sv
// ---------------------------------------------------------------------------
// offset_ctrl_param
// Parametrised offset selector for the logic-analyzer capture window.
// Two debounced push-button levels step an OFFSET_W-bit offset up or down
// by STEP, saturating or wrapping at 0 / MAX_VAL, with optional
// press-and-hold auto-repeat.
//
// Ports:
//   clk        system clock
//   i_reset    synchronous reset, active-high
//   i_SW_up    debounced up button level, 1 = pressed
//   i_SW_down  debounced down button level, 1 = pressed
//   o_offset   current offset, registered
//   o_step     one-cycle pulse while a freshly changed o_offset is visible
//   o_at_min   o_offset == 0
//   o_at_max   o_offset == MAX_VAL
//
// FSM states:
//   state  | meaning
//   IDLE   | waiting for a clean rising edge on one button
//   HOLD   | initial step taken, timing the hold delay
//   REPEAT | auto-repeating every REPEAT_CYCLES while held
// ---------------------------------------------------------------------------
module offset_ctrl_param #(
    parameter int OFFSET_W      = 2,
    parameter int MAX_VAL       = 3,
    parameter int STEP          = 1,
    parameter int WRAP          = 0,
    parameter int REPEAT_EN     = 1,
    parameter int HOLD_CYCLES   = 12500000,
    parameter int REPEAT_CYCLES = 2500000,
    parameter int CNT_W         = 24
) (
    input  logic                clk,
    input  logic                i_reset,
    input  logic                i_SW_up,
    input  logic                i_SW_down,
    output logic [OFFSET_W-1:0] o_offset,
    output logic                o_step,
    output logic                o_at_min,
    output logic                o_at_max
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        HOLD   = 2'd1,
        REPEAT = 2'd2
    } state_t;

    localparam logic [OFFSET_W:0]   MAX_X   = (OFFSET_W+1)'(MAX_VAL);
    localparam logic [OFFSET_W:0]   STEP_X  = (OFFSET_W+1)'(STEP);
    localparam logic [OFFSET_W:0]   MOD_X   = (OFFSET_W+1)'(MAX_VAL + 1);
    localparam logic [CNT_W-1:0]    HOLD_TC = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0]    REP_TC  = CNT_W'(REPEAT_CYCLES - 1);

    state_t                state_q;
    logic                  dir_up_q;      // 1 = UP, 0 = DOWN
    logic [CNT_W-1:0]      cnt_q;
    logic [OFFSET_W-1:0]   offset_q;
    logic                  step_q;
    logic                  sw_up_q;
    logic                  sw_dn_q;

    logic                  rise_up;
    logic                  rise_dn;
    logic                  idle_go_up;
    logic                  idle_go_dn;
    logic                  abort;
    logic                  step_dir_up;
    logic [OFFSET_W:0]     up_sum;
    logic [OFFSET_W:0]     up_val_x;
    logic [OFFSET_W:0]     dn_val_x;
    logic [OFFSET_W-1:0]   step_val_d;
    logic                  step_chg_d;

    always_comb begin
        rise_up    = i_SW_up & ~sw_up_q;
        rise_dn    = i_SW_down & ~sw_dn_q;
        // A rise only counts while the other button is fully released.
        idle_go_up = rise_up & ~i_SW_down;
        idle_go_dn = rise_dn & ~i_SW_up;
        abort      = dir_up_q ? (~i_SW_up | i_SW_down) : (~i_SW_down | i_SW_up);
        // In IDLE the direction comes from the rising button, later from dir_up_q.
        step_dir_up = (state_q == IDLE) ? idle_go_up : dir_up_q;

        up_sum = {1'b0, offset_q} + STEP_X;
        if (up_sum <= MAX_X)
            up_val_x = up_sum;
        else if (WRAP != 0)
            up_val_x = up_sum - MOD_X;
        else
            up_val_x = MAX_X;

        if ({1'b0, offset_q} >= STEP_X)
            dn_val_x = {1'b0, offset_q} - STEP_X;
        else if (WRAP != 0)
            dn_val_x = {1'b0, offset_q} + MOD_X - STEP_X;
        else
            dn_val_x = '0;

        step_val_d = step_dir_up ? up_val_x[OFFSET_W-1:0] : dn_val_x[OFFSET_W-1:0];
        step_chg_d = (step_val_d != offset_q);
    end

    always_ff @(posedge clk) begin
        if (i_reset) begin
            state_q  <= IDLE;
            dir_up_q <= 1'b1;
            cnt_q    <= '0;
            offset_q <= '0;
            step_q   <= 1'b0;
            // Load current levels so a button held through reset gives no edge.
            sw_up_q  <= i_SW_up;
            sw_dn_q  <= i_SW_down;
        end else begin
            sw_up_q <= i_SW_up;
            sw_dn_q <= i_SW_down;
            step_q  <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (idle_go_up || idle_go_dn) begin
                        offset_q <= step_val_d;
                        step_q   <= step_chg_d;
                        dir_up_q <= idle_go_up;
                        cnt_q    <= '0;
                        state_q  <= HOLD;
                    end
                end
                HOLD: begin
                    if (abort) begin
                        cnt_q   <= '0;
                        state_q <= IDLE;
                    end else if (cnt_q == HOLD_TC) begin
                        if (REPEAT_EN != 0) begin
                            offset_q <= step_val_d;
                            step_q   <= step_chg_d;
                            cnt_q    <= '0;
                            state_q  <= REPEAT;
                        end
                        // Without auto-repeat the counter parks at its terminal value.
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                REPEAT: begin
                    if (abort) begin
                        cnt_q   <= '0;
                        state_q <= IDLE;
                    end else if (cnt_q == REP_TC) begin
                        offset_q <= step_val_d;
                        step_q   <= step_chg_d;
                        cnt_q    <= '0;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                default: begin
                    cnt_q   <= '0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign o_offset = offset_q;
    assign o_step   = step_q;
    assign o_at_min = (offset_q == '0);
    assign o_at_max = ({1'b0, offset_q} == MAX_X);

endmodule

// File: tb/tb_offset_ctrl_param.sv
// ---------------------------------------------------------------------------
// tb_offset_ctrl_param
// Three instances share the button stimulus: saturate+repeat, wrap+repeat,
// saturate without repeat. A press-age reference model predicts each one.
// ---------------------------------------------------------------------------
module tb_offset_ctrl_param;

    localparam int OW   = 4;
    localparam int MAXV = 9;
    localparam int STP  = 2;
    localparam int HOLD = 8;
    localparam int REP  = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic up  = 1'b0;
    logic dn  = 1'b0;

    logic [OW-1:0] off  [3];
    logic          stp  [3];
    logic          amin [3];
    logic          amax [3];

    always #5 clk = ~clk;

    offset_ctrl_param #(.OFFSET_W(OW), .MAX_VAL(MAXV), .STEP(STP), .WRAP(0),
        .REPEAT_EN(1), .HOLD_CYCLES(HOLD), .REPEAT_CYCLES(REP), .CNT_W(4)) u_sat (
        .clk(clk), .i_reset(rst), .i_SW_up(up), .i_SW_down(dn),
        .o_offset(off[0]), .o_step(stp[0]), .o_at_min(amin[0]), .o_at_max(amax[0]));

    offset_ctrl_param #(.OFFSET_W(OW), .MAX_VAL(MAXV), .STEP(STP), .WRAP(1),
        .REPEAT_EN(1), .HOLD_CYCLES(HOLD), .REPEAT_CYCLES(REP), .CNT_W(4)) u_wrap (
        .clk(clk), .i_reset(rst), .i_SW_up(up), .i_SW_down(dn),
        .o_offset(off[1]), .o_step(stp[1]), .o_at_min(amin[1]), .o_at_max(amax[1]));

    offset_ctrl_param #(.OFFSET_W(OW), .MAX_VAL(MAXV), .STEP(STP), .WRAP(0),
        .REPEAT_EN(0), .HOLD_CYCLES(HOLD), .REPEAT_CYCLES(REP), .CNT_W(4)) u_norep (
        .clk(clk), .i_reset(rst), .i_SW_up(up), .i_SW_down(dn),
        .o_offset(off[2]), .o_step(stp[2]), .o_at_min(amin[2]), .o_at_max(amax[2]));

    int n_cmp = 0;
    int n_err = 0;

    // Reference model: active press (+1 up, -1 down, 0 none) and its age in cycles.
    int  p_wrap [3] = '{0, 1, 0};
    int  p_rep  [3] = '{1, 1, 0};
    int  m_off  [3];
    int  m_act  [3];
    int  m_age  [3];
    bit  m_stp  [3];
    bit  pu = 1'b0;
    bit  pd = 1'b0;

    task automatic chk(input string tag, input int obs, input int exp);
        n_cmp++;
        if (obs != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic int next_val(input int v, input int d, input int wrap);
        int r;
        r = v + d * STP;
        if (r > MAXV) r = wrap ? r - (MAXV + 1) : MAXV;
        if (r < 0)    r = wrap ? r + (MAXV + 1) : 0;
        return r;
    endfunction

    task automatic model_edge();
        for (int i = 0; i < 3; i++) begin
            int  old;
            int  d;
            bit  held, other;
            old      = m_off[i];
            d        = 0;
            m_stp[i] = 1'b0;
            if (rst) begin
                m_off[i] = 0;
                m_act[i] = 0;
                m_age[i] = 0;
            end else if (m_act[i] == 0) begin
                if (up && !pu && !dn)      d = 1;
                else if (dn && !pd && !up) d = -1;
                if (d != 0) begin
                    m_act[i] = d;
                    m_age[i] = 0;
                end
            end else begin
                held  = (m_act[i] > 0) ? up : dn;
                other = (m_act[i] > 0) ? dn : up;
                if (!held || other) begin
                    m_act[i] = 0;
                end else begin
                    m_age[i]++;
                    if (p_rep[i] != 0 && m_age[i] >= HOLD && ((m_age[i] - HOLD) % REP) == 0)
                        d = m_act[i];
                end
            end
            if (d != 0) begin
                m_off[i] = next_val(old, d, p_wrap[i]);
                m_stp[i] = (m_off[i] != old);
            end
        end
        pu = up;
        pd = dn;
    endtask

    task automatic tick(input bit u, input bit d, input bit r);
        up  = u;
        dn  = d;
        rst = r;
        @(posedge clk);
        model_edge();
        #1;
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("offset[%0d]", i), int'(off[i]), m_off[i]);
            chk($sformatf("step[%0d]", i),   int'(stp[i]), int'(m_stp[i]));
            chk($sformatf("at_min[%0d]", i), int'(amin[i]), int'(m_off[i] == 0));
            chk($sformatf("at_max[%0d]", i), int'(amax[i]), int'(m_off[i] == MAXV));
        end
    endtask

    task automatic press(input bit u, input bit d, input int hi, input int lo);
        for (int k = 0; k < hi; k++) tick(u, d, 1'b0);
        for (int k = 0; k < lo; k++) tick(1'b0, 1'b0, 1'b0);
    endtask

    task automatic do_reset();
        tick(up, dn, 1'b1);
        tick(up, dn, 1'b0);
    endtask

    initial begin
        int step_seen;
        #1;
        tick(1'b0, 1'b0, 1'b1);
        tick(1'b0, 1'b0, 1'b1);
        chk("reset_offset", int'(off[0]), 0);
        chk("reset_step",   int'(stp[0]), 0);
        chk("reset_at_min", int'(amin[0]), 1);

        // Six short up presses: saturating copy 2,4,6,8,9,9; wrap copy rolls over.
        step_seen = 0;
        for (int p = 0; p < 6; p++) begin
            tick(1'b1, 1'b0, 1'b0);
            step_seen += int'(stp[0]);
            tick(1'b1, 1'b0, 1'b0);
            tick(1'b1, 1'b0, 1'b0);
            for (int k = 0; k < 3; k++) tick(1'b0, 1'b0, 1'b0);
        end
        chk("sat_final", int'(off[0]), 9);
        chk("sat_at_max", int'(amax[0]), 1);
        chk("sat_step_count", step_seen, 5);

        // Wrap copy from 8: up -> 0, down -> 8.
        do_reset();
        for (int p = 0; p < 4; p++) press(1'b1, 1'b0, 3, 3);
        chk("wrap_at8", int'(off[1]), 8);
        tick(1'b1, 1'b0, 1'b0);
        chk("wrap_up_to0", int'(off[1]), 0);
        chk("wrap_up_step", int'(stp[1]), 1);
        press(1'b1, 1'b0, 2, 3);
        tick(1'b0, 1'b1, 1'b0);
        chk("wrap_dn_to8", int'(off[1]), 8);
        chk("wrap_dn_step", int'(stp[1]), 1);
        press(1'b0, 1'b1, 2, 3);

        // Held up from 0: auto-repeat sequence.
        do_reset();
        press(1'b1, 1'b0, 30, 4);

        // Simultaneous rise, then down pressed during HOLD aborts.
        do_reset();
        press(1'b1, 1'b1, 3, 3);
        chk("both_rise_off", int'(off[0]), 0);
        press(1'b1, 1'b0, 3, 0);
        press(1'b1, 1'b1, 12, 0);
        press(1'b1, 1'b0, 12, 3);
        chk("abort_no_more", int'(off[0]), 2);

        // Reset mid-REPEAT with up held.
        do_reset();
        for (int k = 0; k < 14; k++) tick(1'b1, 1'b0, 1'b0);
        tick(1'b1, 1'b0, 1'b1);
        chk("rst_mid_off", int'(off[0]), 0);
        press(1'b1, 1'b0, 20, 2);
        chk("rst_held_nostep", int'(off[0]), 0);
        press(1'b1, 1'b0, 3, 3);
        chk("rst_repress", int'(off[0]), 2);

        // No-repeat copy: hold down 50 cycles from 6.
        do_reset();
        for (int p = 0; p < 3; p++) press(1'b1, 1'b0, 3, 3);
        press(1'b0, 1'b1, 50, 3);
        chk("norep_hold_dn", int'(off[2]), 4);

        // Randomized button activity with occasional reset.
        begin
            bit ru, rd;
            ru = 1'b0;
            rd = 1'b0;
            for (int c = 0; c < 3000; c++) begin
                if ($urandom_range(0, 9) == 0) ru = ~ru;
                if ($urandom_range(0, 14) == 0) rd = ~rd;
                tick(ru, rd, ($urandom_range(0, 299) == 0));
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
